// File: rtl/uk101_acia.sv
// 6850-style serial port for the UK101 bus: fixed 8N1 framing, single TX holding
// register, single RX data register and an active-low IRQ to the 6502 core.
module uk101_acia #(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       cpu_clk,
  input  logic       rst_n,
  input  logic       uart_cs,
  input  logic       uart_rs,
  input  logic       uart_rd,
  input  logic       uart_we,
  input  logic [7:0] uart_din,
  output logic [7:0] uart_dout,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       irq_n
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BIT_HALF = 16'(BAUD_DIV / 2);

  logic        wr, rd_acc, rd_q, rd_first, rd_data_first, wr_data, wr_ctrl, mr;
  logic        rie, tie, tdre, rdrf, fe, ovrn, irq;
  logic        rie_n, tie_n, tdre_n, rdrf_n, fe_n, ovrn_n;
  logic [7:0]  thr, rdr, rdr_n;
  ser_state_t  tx_state, tx_state_n, rx_state, rx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic        tx_load, txd_n, txd_q, rx_done;
  logic        rxd_s1, rxd_s2, rxd_prev;

  assign wr            = ~uart_cs & uart_we;
  assign rd_acc        = ~uart_cs & uart_rd;
  assign rd_first      = rd_acc & ~rd_q;
  assign rd_data_first = rd_first & uart_rs;
  assign wr_data       = wr & uart_rs;
  assign wr_ctrl       = wr & ~uart_rs;
  assign mr            = wr_ctrl & (uart_din[1:0] == 2'b11);

  assign irq       = (rie & (rdrf | ovrn)) | (tie & tdre);
  assign uart_dout = uart_rs ? rdr : {irq, 1'b0, ovrn, fe, 2'b00, tdre, rdrf};
  assign uart_txd  = txd_q;

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      rie      <= 1'b0;
      tie      <= 1'b0;
      tdre     <= 1'b1;
      rdrf     <= 1'b0;
      fe       <= 1'b0;
      ovrn     <= 1'b0;
      thr      <= '0;
      rdr      <= '0;
      irq_n    <= 1'b1;
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rd_q     <= rd_acc;
      rie      <= rie_n;
      tie      <= tie_n;
      tdre     <= tdre_n;
      rdrf     <= rdrf_n;
      fe       <= fe_n;
      ovrn     <= ovrn_n;
      if (wr_data) thr <= uart_din;
      rdr      <= rdr_n;
      irq_n    <= ~irq;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  // Transmitter: the shifter reloads straight from THR at the end of STOP so
  // queued bytes go out without an idle gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_load    = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (!tdre) begin
          tx_load    = 1'b1;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_idx_n   = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (!tdre) begin
            tx_load    = 1'b1;
            tx_state_n = S_START;
          end else begin
            tx_state_n = S_IDLE;
          end
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load) tx_shift_n = thr;
    if (mr) begin
      tx_state_n = S_IDLE;
      tx_cnt_n   = '0;
      tx_idx_n   = '0;
      tx_load    = 1'b0;
    end
    txd_n = 1'b1;
    if (tx_state_n == S_START) txd_n = 1'b0;
    else if (tx_state_n == S_DATA) txd_n = tx_shift_n[0];
  end

  // Receiver works on the synchronised line; START re-checks at mid-bit to reject glitches.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rxd_prev & ~rxd_s2) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_cnt == BIT_HALF) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rxd_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxd_s2, rx_shift[7:1]};
          rx_idx_n   = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_done    = 1'b1;
          rx_cnt_n   = '0;
          rx_state_n = S_IDLE;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
    if (mr) begin
      rx_state_n = S_IDLE;
      rx_cnt_n   = '0;
      rx_idx_n   = '0;
      rx_done    = 1'b0;
    end
  end

  // Status: a data read clears its flags before a coincident stop sample is applied.
  always_comb begin
    rie_n  = rie;
    tie_n  = tie;
    tdre_n = tdre;
    if (tx_load) tdre_n = 1'b1;
    if (wr_data) tdre_n = 1'b0;
    rdrf_n = rdrf & ~rd_data_first;
    fe_n   = fe & ~rd_data_first;
    ovrn_n = ovrn & ~rd_data_first;
    rdr_n  = rdr;
    if (rx_done) begin
      if (!rdrf_n) begin
        rdr_n  = rx_shift;
        rdrf_n = 1'b1;
        fe_n   = ~rxd_s2;
      end else begin
        ovrn_n = 1'b1;
      end
    end
    if (wr_ctrl && !mr) begin
      rie_n = uart_din[7];
      tie_n = (uart_din[6:5] == 2'b01);
    end
    if (mr) begin
      tdre_n = 1'b1;
      rdrf_n = 1'b0;
      fe_n   = 1'b0;
      ovrn_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uk101_acia.sv
// Directed bench for uk101_acia at BAUD_DIV=8: bus access, TX framing, RX flags and IRQ.
module tb_uk101_acia;

  logic       cpu_clk = 1'b0;
  logic       rst_n;
  logic       uart_cs, uart_rs, uart_rd, uart_we;
  logic [7:0] uart_din;
  logic [7:0] uart_dout;
  logic       uart_txd;
  logic       uart_rxd;
  logic       irq_n;

  int unsigned tests = 0;
  int unsigned fails = 0;

  uk101_acia #(.BAUD_DIV(8)) dut (
    .cpu_clk  (cpu_clk),
    .rst_n    (rst_n),
    .uart_cs  (uart_cs),
    .uart_rs  (uart_rs),
    .uart_rd  (uart_rd),
    .uart_we  (uart_we),
    .uart_din (uart_din),
    .uart_dout(uart_dout),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .irq_n    (irq_n)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected txd for sample k of an 80-cycle frame at 8 cycles per bit.
  function automatic logic exp_txd(input int unsigned k, input logic [7:0] d);
    if (k < 8) return 1'b0;
    if (k < 72) return d[(k - 8) / 8];
    return 1'b1;
  endfunction

  task automatic bus_idle();
    uart_cs = 1'b1;
    uart_we = 1'b0;
    uart_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic rs, input logic [7:0] d);
    @(negedge cpu_clk);
    uart_cs = 1'b0; uart_we = 1'b1; uart_rs = rs; uart_din = d;
    @(negedge cpu_clk);
    bus_idle();
  endtask

  task automatic cpu_read(input logic rs, output logic [7:0] d);
    @(negedge cpu_clk);
    uart_cs = 1'b0; uart_rd = 1'b1; uart_rs = rs;
    #1 d = uart_dout;
    @(negedge cpu_clk);
    bus_idle();
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = fr[b];
      repeat (8) @(negedge cpu_clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] st;
    tests++;
    if (uart_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
    tests++;
    if (irq_n !== 1'b1) begin fails++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    cpu_read(1'b0, st);
    tests++;
    if (st !== 8'h02) begin fails++; $display("FAIL reset_status: got %h want 02", st); end
  endtask

  task automatic test_tx_frame();
    logic got[90];
    int unsigned bad;
    int unsigned first_bad;
    for (int i = 0; i < 90; i++) begin
      @(negedge cpu_clk);
      got[i] = uart_txd;
      bus_idle();
      if (i == 0) begin
        uart_cs = 1'b0; uart_we = 1'b1; uart_rs = 1'b1; uart_din = 8'h55;
      end
      if (i == 1 || i == 3) begin
        uart_cs = 1'b0; uart_rd = 1'b1; uart_rs = 1'b0;
        #1;
        tests++;
        if (i == 1 && uart_dout !== 8'h00) begin
          fails++; $display("FAIL tx_tdre_clear: got %h want 00", uart_dout);
        end
        if (i == 3 && uart_dout !== 8'h02) begin
          fails++; $display("FAIL tx_tdre_set: got %h want 02", uart_dout);
        end
      end
    end
    bad = 0; first_bad = 0;
    for (int i = 0; i < 90; i++) begin
      logic e;
      e = (i < 2) ? 1'b1 : ((i < 82) ? exp_txd(i - 2, 8'h55) : 1'b1);
      if (got[i] !== e) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tx_frame_55: %0d bad samples, first at %0d got %b want %b", bad, first_bad,
               got[first_bad], (first_bad < 2) ? 1'b1 : ((first_bad < 82) ? exp_txd(first_bad - 2, 8'h55) : 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic got[170];
    int unsigned bad;
    int unsigned first_bad;
    for (int i = 0; i < 170; i++) begin
      @(negedge cpu_clk);
      got[i] = uart_txd;
      bus_idle();
      if (i == 0) begin
        uart_cs = 1'b0; uart_we = 1'b1; uart_rs = 1'b1; uart_din = 8'hA5;
      end
      if (i == 4) begin
        uart_cs = 1'b0; uart_we = 1'b1; uart_rs = 1'b1; uart_din = 8'h3C;
      end
    end
    bad = 0; first_bad = 0;
    for (int i = 0; i < 170; i++) begin
      logic e;
      if (i < 2) e = 1'b1;
      else if (i < 82) e = exp_txd(i - 2, 8'hA5);
      else if (i < 162) e = exp_txd(i - 82, 8'h3C);
      else e = 1'b1;
      if (got[i] !== e) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tx_back_to_back: %0d bad samples, first at %0d got %b", bad, first_bad, got[first_bad]);
    end
  endtask

  task automatic test_rx_irq();
    logic [7:0] d;
    cpu_write(1'b0, 8'h80);
    send_rx(8'hC3, 1'b1);
    repeat (2) @(negedge cpu_clk);
    tests++;
    if (irq_n !== 1'b0) begin fails++; $display("FAIL rx_irq_assert: got %b want 0", irq_n); end
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h83) begin fails++; $display("FAIL rx_status: got %h want 83", d); end
    cpu_read(1'b1, d);
    tests++;
    if (d !== 8'hC3) begin fails++; $display("FAIL rx_data: got %h want c3", d); end
    @(negedge cpu_clk);
    tests++;
    if (irq_n !== 1'b1) begin fails++; $display("FAIL rx_irq_release: got %b want 1", irq_n); end
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL rx_status_cleared: got %h want 02", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    cpu_write(1'b0, 8'h00);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (2) @(negedge cpu_clk);
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h23) begin fails++; $display("FAIL ovrn_status: got %h want 23", d); end
    cpu_read(1'b1, d);
    tests++;
    if (d !== 8'h11) begin fails++; $display("FAIL ovrn_data: got %h want 11", d); end
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL ovrn_cleared: got %h want 02", d); end
  endtask

  task automatic test_framing();
    logic [7:0] d;
    send_rx(8'h5A, 1'b0);
    repeat (2) @(negedge cpu_clk);
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h13) begin fails++; $display("FAIL fe_status: got %h want 13", d); end
    cpu_read(1'b1, d);
    tests++;
    if (d !== 8'h5A) begin fails++; $display("FAIL fe_data: got %h want 5a", d); end
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL fe_cleared: got %h want 02", d); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    uart_rxd = 1'b0;
    repeat (3) @(negedge cpu_clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge cpu_clk);
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL glitch_status: got %h want 02", d); end
  endtask

  task automatic test_master_reset();
    logic [7:0] d;
    int unsigned n;
    int unsigned highs;
    cpu_write(1'b1, 8'hF0);
    n = 0;
    while (uart_txd !== 1'b0 && n < 50) begin
      @(negedge cpu_clk);
      n++;
    end
    repeat (12) @(negedge cpu_clk);
    tests++;
    if (uart_txd !== 1'b0) begin fails++; $display("FAIL mr_frame_active: got %b want 0", uart_txd); end
    cpu_write(1'b0, 8'h03);
    tests++;
    if (uart_txd !== 1'b1) begin fails++; $display("FAIL mr_txd: got %b want 1", uart_txd); end
    cpu_read(1'b0, d);
    tests++;
    if (d !== 8'h02) begin fails++; $display("FAIL mr_status: got %h want 02", d); end
    highs = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge cpu_clk);
      if (uart_txd === 1'b1) highs++;
    end
    tests++;
    if (highs != 90) begin fails++; $display("FAIL mr_txd_idle: got %0d high cycles want 90", highs); end
  endtask

  initial begin
    rst_n    = 1'b0;
    uart_rs  = 1'b0;
    uart_din = '0;
    uart_rxd = 1'b1;
    bus_idle();
    repeat (3) @(negedge cpu_clk);
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx_irq();
    test_overrun();
    test_framing();
    test_glitch();
    test_master_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
